jt9346_dump_seq: RTL and testbench

JT9346_DUMP_SEQ -- requirements
Module: jt9346_dump_seq

---
 rtl/jt9346_dump_seq.sv | 139 +++++++++++++
 tb/tb_jt9346_dump_seq.sv | 237 +++++++++++++++++++++++
 2 files changed

// File: rtl/jt9346_dump_seq.sv
// ============================================================================
// jt9346_dump_seq
// Save/load sequencer that streams a whole EEPROM image through the byte-wide
// dump port. A save reads every byte (ascending address) out on a
// valid/ready stream. A load writes every byte from a valid/ready stream
// into the EEPROM.
// Optional build macro: JT9346_AUTOSAVE_EN. When defined, a dirty EEPROM
// starts a save on its own whenever the sequencer is idle and no load is
// requested.
// Revision: 1.0
// ============================================================================
`default_nettype none

module jt9346_dump_seq #(
  parameter int AW = 7
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          save_req,
  input  logic          load_req,
  input  logic          abort,
  output logic          busy,
  output logic          done,
  output logic          dirty,
  output logic [7:0]    tx_data,
  output logic          tx_valid,
  input  logic          tx_ready,
  input  logic [7:0]    rx_data,
  input  logic          rx_valid,
  output logic          rx_ready,
  output logic [AW-1:0] dump_addr,
  output logic          dump_we,
  output logic [7:0]    dump_din,
  input  logic [7:0]    dump_dout,
  output logic          dump_clr,
  input  logic          dump_flag
);

  localparam logic [2:0] IDLE    = 3'd0;
  localparam logic [2:0] RD_ADDR = 3'd1;
  localparam logic [2:0] RD_WAIT = 3'd2;
  localparam logic [2:0] RD_SEND = 3'd3;
  localparam logic [2:0] WR_WAIT = 3'd4;
  localparam logic [2:0] WR_STRB = 3'd5;
  localparam logic [2:0] FIN     = 3'd6;

  logic [2:0]    state;
  logic [AW-1:0] addr;
  logic          start_save;
  logic          last_addr;

  // Decide whether an idle sequencer should begin a save this cycle.
  always_comb begin
`ifdef JT9346_AUTOSAVE_EN
    start_save = save_req | (dirty & ~load_req);
`else
    start_save = save_req;
`endif
  end

  assign last_addr = (addr == {AW{1'b1}});
  assign dump_addr = addr;

  // Main sequencer: state, address counter, data registers and clear pulse.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      addr     <= '0;
      tx_data  <= 8'h00;
      dump_din <= 8'h00;
      dump_clr <= 1'b0;
      dirty    <= 1'b0;
    end else begin
      dirty    <= dump_flag;
      dump_clr <= 1'b0;
      if (abort && (state != IDLE)) begin
        // Abort outranks everything; completed writes stay in the EEPROM.
        state <= IDLE;
      end else begin
        case (state)
          IDLE: begin
            if (start_save) begin
              state    <= RD_ADDR;
              addr     <= '0;
              // Clearing the flag at save start lets writes made during the
              // save mark the image dirty again.
              dump_clr <= 1'b1;
            end else if (load_req) begin
              state <= WR_WAIT;
              addr  <= '0;
            end
          end
          RD_ADDR: state <= RD_WAIT;
          RD_WAIT: begin
            // The EEPROM read data is valid one cycle after the address.
            tx_data <= dump_dout;
            state   <= RD_SEND;
          end
          RD_SEND: begin
            if (tx_ready) begin
              addr  <= addr + 1'b1;
              state <= last_addr ? FIN : RD_ADDR;
            end
          end
          WR_WAIT: begin
            if (rx_valid) begin
              dump_din <= rx_data;
              state    <= WR_STRB;
            end
          end
          WR_STRB: begin
            addr <= addr + 1'b1;
            if (last_addr) begin
              state    <= FIN;
              // A freshly loaded image matches the host copy: not dirty.
              dump_clr <= 1'b1;
            end else begin
              state <= WR_WAIT;
            end
          end
          FIN:     state <= IDLE;
          default: state <= IDLE;
        endcase
      end
    end
  end

  // Handshake and status outputs decode straight from the state register.
  always_comb begin
    busy     = (state != IDLE);
    done     = (state == FIN);
    tx_valid = (state == RD_SEND);
    rx_ready = (state == WR_WAIT);
    dump_we  = (state == WR_STRB);
  end

endmodule

`default_nettype wire

// File: tb/tb_jt9346_dump_seq.sv
// ============================================================================
// tb_jt9346_dump_seq
// Self-checking bench for jt9346_dump_seq with AW=3 and a behavioural EEPROM
// (synchronous read, write flag set by writes, cleared by dump_clr).
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_jt9346_dump_seq;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       save_req = 1'b0, load_req = 1'b0, abort = 1'b0;
  logic       busy, done, dirty;
  logic [7:0] tx_data;
  logic       tx_valid;
  logic       tx_ready = 1'b0;
  logic [7:0] rx_data = 8'h00;
  logic       rx_valid = 1'b0;
  logic       rx_ready;
  logic [2:0] dump_addr;
  logic       dump_we;
  logic [7:0] dump_din;
  logic [7:0] dump_dout = 8'h00;
  logic       dump_clr;
  logic       dump_flag = 1'b0;

  logic [7:0] mem [8];

  int n_checks = 0, n_fail = 0;
  int cyc = 0, last_tx_cyc = 0, done_cyc = 0, done_cnt = 0, clr_cnt = 0, rx_seen = 0;
  logic       prev_pending = 1'b0;
  logic [7:0] prev_data = 8'h00;

  logic [7:0]  tx_q [$];
  logic [10:0] wr_q [$];

  jt9346_dump_seq #(.AW(3)) dut (
    .clk(clk), .rst_n(rst_n), .save_req(save_req), .load_req(load_req),
    .abort(abort), .busy(busy), .done(done), .dirty(dirty),
    .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
    .rx_data(rx_data), .rx_valid(rx_valid), .rx_ready(rx_ready),
    .dump_addr(dump_addr), .dump_we(dump_we), .dump_din(dump_din),
    .dump_dout(dump_dout), .dump_clr(dump_clr), .dump_flag(dump_flag)
  );

  always #5 clk = ~clk;

  // EEPROM model: registered read, write flag
  always @(posedge clk) begin
    dump_dout <= mem[dump_addr];
    if (dump_we) begin
      mem[dump_addr] <= dump_din;
      dump_flag      <= 1'b1;
    end else if (dump_clr) begin
      dump_flag <= 1'b0;
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Monitor: pops expected tx bytes / writes when the DUT presents them
  always @(negedge clk) begin
    cyc++;
    if (rst_n) begin
      if (prev_pending) begin
        chk("tx_hold_valid", {31'd0, tx_valid}, 32'd1);
        chk("tx_hold_data", {24'd0, tx_data}, {24'd0, prev_data});
      end
      if (tx_valid && tx_ready) begin
        if (tx_q.size() == 0) begin
          n_checks++; n_fail++;
          $display("FAIL tx_unexpected: got %0h expected no byte", tx_data);
        end else begin
          chk("tx_byte", {24'd0, tx_data}, {24'd0, tx_q.pop_front()});
        end
        last_tx_cyc = cyc;
      end
      if (dump_we) begin
        if (wr_q.size() == 0) begin
          n_checks++; n_fail++;
          $display("FAIL wr_unexpected: got addr %0h data %0h expected no write", dump_addr, dump_din);
        end else begin
          chk("wr_addr_data", {21'd0, dump_addr, dump_din}, {21'd0, wr_q.pop_front()});
        end
      end
      if (done) begin done_cnt++; done_cyc = cyc; end
      if (dump_clr) clr_cnt++;
      if (rx_ready) rx_seen++;
      prev_pending = tx_valid && !tx_ready && !abort;
      prev_data    = tx_data;
    end else begin
      prev_pending = 1'b0;
    end
  end

  task automatic clr_counts();
    done_cnt = 0; clr_cnt = 0; rx_seen = 0;
  endtask

  task automatic pulse_start(input logic s, input logic l);
    @(posedge clk); #1; save_req = s; load_req = l;
    @(posedge clk); #1; save_req = 1'b0; load_req = 1'b0;
  endtask

  task automatic wait_done(input string name);
    for (int k = 0; k < 300; k++) begin
      @(negedge clk);
      if (done) break;
    end
    chk(name, {31'd0, done}, 32'd1);
    @(posedge clk); #1;
  endtask

  task automatic push_tx(input int n);
    for (int i = 0; i < n; i++) tx_q.push_back(mem[i]);
  endtask

  task automatic load_bytes(input int n, input logic [7:0] base);
    for (int i = 0; i < n; i++) begin
      wr_q.push_back({i[2:0], base + i[7:0]});
      @(posedge clk); #1; rx_valid = 1'b1; rx_data = base + i[7:0];
      for (int k = 0; k < 50; k++) begin
        @(negedge clk);
        if (rx_ready) break;
      end
      chk("rx_accept", {31'd0, rx_ready}, 32'd1);
      @(posedge clk); #1; rx_valid = 1'b0;
    end
  endtask

  task automatic chk_all_zero(input string name);
    chk(name, {7'd0, busy, done, dirty, tx_valid, rx_ready, dump_we, dump_clr,
               tx_data, dump_din, dump_addr}, 32'd0);
  endtask

  initial begin
    for (int i = 0; i < 8; i++) mem[i] = 8'h10 + i[7:0];

    // Reset values
    repeat (3) @(negedge clk);
    chk_all_zero("reset_outputs");
    @(posedge clk); #1; rst_n = 1'b1;
    repeat (2) @(posedge clk);

    // Save of preloaded image with tx_ready held high
    clr_counts(); push_tx(8); tx_ready = 1'b1;
    pulse_start(1'b1, 1'b0);
    wait_done("save1_done");
    chk("save1_done_latency", done_cyc - last_tx_cyc, 32'd1);
    chk("save1_clr_pulses", clr_cnt, 32'd1);
    chk("save1_all_bytes", tx_q.size(), 32'd0);
    @(negedge clk);
    chk("save1_idle", {31'd0, busy}, 32'd0);

    // Load 0xA0..0xA7 with a gap after every byte
    clr_counts();
    pulse_start(1'b0, 1'b1);
    load_bytes(8, 8'hA0);
    wait_done("load1_done");
    chk("load1_all_writes", wr_q.size(), 32'd0);
    for (int i = 0; i < 8; i++) chk("load1_mem", {24'd0, mem[i]}, 32'hA0 + i);
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("load1_not_dirty", {31'd0, dirty}, 32'd0);

    // Save with a 5-cycle tx_ready stall starting at byte 3
    clr_counts(); push_tx(8); tx_ready = 1'b1;
    pulse_start(1'b1, 1'b0);
    for (int k = 0; k < 100; k++) begin
      @(negedge clk);
      if (tx_valid && tx_ready && dump_addr == 3'd2) break;
    end
    chk("stall_reach_byte2", {29'd0, dump_addr}, 32'd2);
    @(posedge clk); #1; tx_ready = 1'b0;
    repeat (5) @(posedge clk);
    #1; tx_ready = 1'b1;
    wait_done("stall_done");
    chk("stall_all_bytes", tx_q.size(), 32'd0);

    // save_req and load_req together: save wins
    clr_counts(); push_tx(8);
    pulse_start(1'b1, 1'b1);
    wait_done("both_done");
    chk("both_all_bytes", tx_q.size(), 32'd0);
    chk("both_no_rx_ready", rx_seen, 32'd0);

    // Abort after 4 load bytes
    clr_counts();
    pulse_start(1'b0, 1'b1);
    load_bytes(4, 8'h50);
    @(negedge clk);
    @(posedge clk); #1; abort = 1'b1;
    @(posedge clk); #1; abort = 1'b0;
    @(negedge clk);
    chk("abort_busy", {31'd0, busy}, 32'd0);
    chk("abort_writes", wr_q.size(), 32'd0);
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("abort_no_done", done_cnt, 32'd0);
    for (int i = 0; i < 4; i++) chk("abort_mem_new", {24'd0, mem[i]}, 32'h50 + i);
    for (int i = 4; i < 8; i++) chk("abort_mem_kept", {24'd0, mem[i]}, 32'hA0 + i);
    chk("abort_dirty", {31'd0, dirty}, 32'd1);

    // Reset in the middle of a save at byte 5
    clr_counts(); push_tx(5); tx_ready = 1'b1;
    pulse_start(1'b1, 1'b0);
    for (int k = 0; k < 100; k++) begin
      @(negedge clk);
      if (tx_valid && tx_ready && dump_addr == 3'd4) break;
    end
    chk("rst_reach_byte4", {29'd0, dump_addr}, 32'd4);
    @(posedge clk); #1; rst_n = 1'b0;
    #1;
    chk_all_zero("rst_outputs");
    chk("rst_bytes_before", tx_q.size(), 32'd0);
    repeat (3) @(posedge clk);
    #1; rst_n = 1'b1;
    push_tx(8);
    pulse_start(1'b1, 1'b0);
    wait_done("rst_resave_done");
    chk("rst_resave_bytes", tx_q.size(), 32'd0);

    repeat (2) @(posedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
